// File: rtl/ifc_pkg.sv
// Shared types, default sizes and the pure ranged priority-encode function
// for the ifc block.
package ifc_pkg;

  localparam int unsigned NUM_ELEM = 4;
  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SEL_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  typedef struct packed {
    logic [NUM_ELEM-1:0][ELEM_W-1:0] vec_in;
    logic [IDX_W-1:0]                left;
    logic [IDX_W-1:0]                right;
  } encoder_func_in;

  typedef struct packed {
    logic [IDX_W-1:0] vec_index;
    logic             found;
    logic             range_err;
  } encoder_func_out;

  // Walk NUM_ELEM positions starting at left (wrapping at NUM_ELEM);
  // only the first span positions belong to the window.
  function automatic encoder_func_out encoder_function(input encoder_func_in fin);
    encoder_func_out fout;
    int unsigned     lo;
    int unsigned     hi;
    int unsigned     span;
    int unsigned     pos;
    fout = '0;
    lo   = 32'(fin.left);
    hi   = 32'(fin.right);
    if ((lo >= NUM_ELEM) || (hi >= NUM_ELEM)) begin
      fout.range_err = 1'b1;
    end else begin
      span = (lo <= hi) ? (hi - lo + 1) : (NUM_ELEM - lo + hi + 1);
      for (int unsigned k = 0; k < NUM_ELEM; k++) begin
        pos = lo + k;
        if (pos >= NUM_ELEM) pos = pos - NUM_ELEM;
        if ((k < span) && !fout.found && (|fin.vec_in[SEL_W'(pos)])) begin
          fout.found     = 1'b1;
          fout.vec_index = IDX_W'(pos);
        end
      end
    end
    return fout;
  endfunction

endpackage

// File: rtl/ifc_if.sv
// Request/result bundle between a requester and the ifc encoder.
interface ifc_if;
  import ifc_pkg::*;

  logic              in_valid;
  logic [ELEM_W-1:0] input_vec [NUM_ELEM];
  logic [IDX_W-1:0]  left;
  logic [IDX_W-1:0]  right;
  logic              out_valid;
  logic [IDX_W-1:0]  vec_index;
  logic              found;
  logic              range_err;

  modport encoder (
    input  in_valid, input_vec, left, right,
    output out_valid, vec_index, found, range_err
  );

  modport requester (
    output in_valid, input_vec, left, right,
    input  out_valid, vec_index, found, range_err
  );
endinterface

// File: rtl/ifc_range_scan.sv
// Combinational windowed scan: thin wrapper around encoder_function.
module ifc_range_scan
  import ifc_pkg::*;
(
  input  encoder_func_in  scan_in,
  output encoder_func_out scan_out_c
);

  assign scan_out_c = encoder_function(scan_in);

endmodule

// File: rtl/ifc.sv
// Registered ranged priority encoder: combinational scan plus one output
// register stage with synchronous active-high reset.
module ifc
  import ifc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ifc_if.encoder    bus
);

  encoder_func_in  scan_in;
  encoder_func_out scan_out_c;
  encoder_func_out res_d;
  encoder_func_out res_q;
  logic            out_valid_d;
  logic            out_valid_q;

  // Pack the unpacked element array into the scan payload.
  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_pack
    assign scan_in.vec_in[g] = bus.input_vec[g];
  end
  assign scan_in.left  = bus.left;
  assign scan_in.right = bus.right;

  ifc_range_scan u_range_scan (
    .scan_in    (scan_in),
    .scan_out_c (scan_out_c)
  );

  // Result fields hold when no request is accepted.
  always_comb begin
    out_valid_d = bus.in_valid;
    res_d       = res_q;
    if (bus.in_valid) res_d = scan_out_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.vec_index = res_q.vec_index;
  assign bus.found     = res_q.found;
  assign bus.range_err = res_q.range_err;

endmodule

// File: tb/tb_ifc.sv
// Directed self-checking bench for the ifc ranged priority encoder.
module tb_ifc;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ifc_if bus ();

  ifc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    bus.input_vec[0] = e0;
    bus.input_vec[1] = e1;
    bus.input_vec[2] = e2;
    bus.input_vec[3] = e3;
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic v, input logic [2:0] l, input logic [2:0] r);
    bus.in_valid = v;
    bus.left     = l;
    bus.right    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [2:0] idx,
                            input logic fnd, input logic rerr);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".vec_index"}, 32'(bus.vec_index), 32'(idx));
    chk({tag, ".found"},     32'(bus.found),     32'(fnd));
    chk({tag, ".range_err"}, 32'(bus.range_err), 32'(rerr));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    set_vec(8'h00, 8'h00, 8'h00, 8'h00);
    step(1'b0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 3'd0);
    expect_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    set_vec(8'h00, 8'h01, 8'h00, 8'h03);
    step(1'b1, 3'd1, 3'd3);
    expect_out("basic", 1'b1, 3'd1, 1'b1, 1'b0);
    step(1'b1, 3'd2, 3'd3);
    expect_out("skip_zero", 1'b1, 3'd3, 1'b1, 1'b0);
    step(1'b1, 3'd2, 3'd2);
    expect_out("single_zero", 1'b1, 3'd0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 3'd3);
    expect_out("single_hit", 1'b1, 3'd3, 1'b1, 1'b0);

    set_vec(8'h80, 8'h00, 8'h00, 8'h00);
    step(1'b1, 3'd3, 3'd1);
    expect_out("wrap_hit0", 1'b1, 3'd0, 1'b1, 1'b0);
    set_vec(8'h00, 8'h00, 8'h10, 8'h00);
    step(1'b1, 3'd3, 3'd1);
    expect_out("wrap_miss", 1'b1, 3'd0, 1'b0, 1'b0);
    set_vec(8'h00, 8'h02, 8'h00, 8'h09);
    step(1'b1, 3'd3, 3'd1);
    expect_out("wrap_order", 1'b1, 3'd3, 1'b1, 1'b0);
    set_vec(8'h00, 8'h02, 8'h00, 8'h00);
    step(1'b1, 3'd3, 3'd1);
    expect_out("wrap_tail", 1'b1, 3'd1, 1'b1, 1'b0);

    step(1'b0, 3'd0, 3'd0);
    expect_out("idle_hold", 1'b0, 3'd1, 1'b1, 1'b0);

    step(1'b1, 3'd4, 3'd1);
    expect_out("rerr_left", 1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd0, 3'd5);
    expect_out("rerr_right", 1'b1, 3'd0, 1'b0, 1'b1);

    set_vec(8'h00, 8'h00, 8'h00, 8'h05);
    step(1'b1, 3'd0, 3'd3);
    expect_out("b2b_0", 1'b1, 3'd3, 1'b1, 1'b0);
    set_vec(8'h07, 8'h00, 8'h00, 8'h00);
    step(1'b1, 3'd0, 3'd3);
    expect_out("b2b_1", 1'b1, 3'd0, 1'b1, 1'b0);
    set_vec(8'h00, 8'h00, 8'h00, 8'h00);
    step(1'b1, 3'd0, 3'd3);
    expect_out("b2b_2", 1'b1, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 3'd3);
    expect_out("b2b_idle", 1'b0, 3'd0, 1'b0, 1'b0);

    set_vec(8'h00, 8'h00, 8'h06, 8'h00);
    step(1'b1, 3'd0, 3'd3);
    expect_out("pre_rst", 1'b1, 3'd2, 1'b1, 1'b0);
    rst = 1'b1;
    set_vec(8'h00, 8'h09, 8'h00, 8'h00);
    step(1'b1, 3'd0, 3'd3);
    expect_out("rst_drop", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b1, 3'd0, 3'd3);
    expect_out("post_rst", 1'b1, 3'd1, 1'b1, 1'b0);
    step(1'b0, 3'd0, 3'd0);
    expect_out("post_idle", 1'b0, 3'd1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
